// File: rtl/result_packer_if.sv
// SRAM write port between result_packer and the result SRAM.
// master drives the write; slave returns ry.
interface result_packer_if #(
  parameter int ADDR_W = 8
);
  logic              ry;
  logic              we_n;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       dataRAM;

  modport master (
    input  ry,
    output we_n,
    output w_addr,
    output dataRAM
  );

  modport slave (
    output ry,
    input  we_n,
    input  w_addr,
    input  dataRAM
  );
endinterface

// File: rtl/result_packer.sv
// Writeback packer: buffers 4-lane ALU sets and writes 2 words/set to SRAM.
// Define RESULT_PACK_SAT_EN to saturate lanes instead of truncating them.
module result_packer #(
  parameter int DATA_W     = 18,
  parameter int OUT_W      = 16,
  parameter int ADDR_W     = 8,
  parameter int NUM_WORDS  = 256,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              web,
  input  logic [DATA_W-1:0] MU1,
  input  logic [DATA_W-1:0] MU2,
  input  logic [DATA_W-1:0] MU3,
  input  logic [DATA_W-1:0] MU4,
  input  logic              clear,
  result_packer_if.master   sram,
  output logic              busy,
  output logic              overflow,
  output logic              wrapped,
  output logic [ADDR_W:0]   wr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] mu4;
    logic [DATA_W-1:0] mu3;
    logic [DATA_W-1:0] mu2;
    logic [DATA_W-1:0] mu1;
  } set_t;

`ifdef RESULT_PACK_SAT_EN
  localparam logic [DATA_W-1:0] SMAX =
    {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = ~SMAX;
`endif

  function automatic logic [OUT_W-1:0] red(
    input logic [DATA_W-1:0] x
  );
`ifdef RESULT_PACK_SAT_EN
    if ($signed(x) > $signed(SMAX))
      red = {1'b0, {(OUT_W-1){1'b1}}};
    else if ($signed(x) < $signed(SMIN))
      red = {1'b1, {(OUT_W-1){1'b0}}};
    else
      red = x[OUT_W-1:0];
`else
    red = x[OUT_W-1:0];
`endif
  endfunction

  state_t            state;
  logic              we_n_q;
  set_t              fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  set_t              head;
  set_t              in_set;
  logic              full;
  logic              empty;
  logic              accept;
  logic              pop;
  logic              push;
  logic              drop;

  assign head   = fifo[rd_ptr];
  assign in_set = '{mu4: MU4, mu3: MU3, mu2: MU2, mu1: MU1};
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign accept = (state != IDLE) && sram.ry;
  assign pop    = (state == WR_HI) && sram.ry;
  // A pop in the same cycle frees the slot the new set lands in.
  assign push   = web && (!full || pop);
  assign drop   = web && full && !pop;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= IDLE;
      we_n_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr     <= '0;
      overflow <= 1'b0;
      wrapped  <= 1'b0;
      wr_count <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= in_set;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop)
        overflow <= 1'b1;
      if (accept) begin
        if (addr == LAST) begin
          addr    <= '0;
          wrapped <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
        if (wr_count != '1)
          wr_count <= wr_count + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!empty || push) begin
            state  <= WR_LO;
            we_n_q <= 1'b0;
          end
        end
        WR_LO: begin
          if (sram.ry)
            state <= WR_HI;
        end
        WR_HI: begin
          if (sram.ry) begin
            if (count > CNT_W'(1) || push) begin
              state <= WR_LO;
            end else begin
              state  <= IDLE;
              we_n_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          we_n_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    data = '0;
    unique case (state)
      WR_LO:   data = {red(head.mu2), red(head.mu1)};
      WR_HI:   data = {red(head.mu4), red(head.mu3)};
      default: data = '0;
    endcase
  end

  assign busy         = (state != IDLE) || !empty;
  assign sram.we_n    = we_n_q;
  assign sram.w_addr  = addr;
  assign sram.dataRAM = data;

endmodule

// File: tb/tb_result_packer.sv
// Bench for result_packer: vector table plus scoreboarded SRAM writes.
// Expected lane data follows RESULT_PACK_SAT_EN the same way the DUT does.
module tb_result_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        web = 1'b0;
  logic [17:0] MU1 = '0;
  logic [17:0] MU2 = '0;
  logic [17:0] MU3 = '0;
  logic [17:0] MU4 = '0;
  logic        busy;
  logic        overflow;
  logic        wrapped;
  logic [8:0]  wr_count;

  result_packer_if #(.ADDR_W(8)) sram ();

  result_packer dut (
    .clk      (clk),
    .rst      (rst),
    .web      (web),
    .MU1      (MU1),
    .MU2      (MU2),
    .MU3      (MU3),
    .MU4      (MU4),
    .clear    (clear),
    .sram     (sram),
    .busy     (busy),
    .overflow (overflow),
    .wrapped  (wrapped),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] mu1;
    logic [17:0] mu2;
    logic [17:0] mu3;
    logic [17:0] mu4;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t       tbl [5];
  wr_t        sb [$];
  logic [7:0] exp_addr = '0;
  int         total = 0;
  int         bad = 0;
  int         nacc = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input bit ok);
    web = 1'b1;
    MU1 = v.mu1;
    MU2 = v.mu2;
    MU3 = v.mu3;
    MU4 = v.mu4;
    if (ok) begin
      sb.push_back('{addr: exp_addr, data: v.lo});
      exp_addr = exp_addr + 8'd1;
      sb.push_back('{addr: exp_addr, data: v.hi});
      exp_addr = exp_addr + 8'd1;
    end
    tick();
    web = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_addr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || sb.size() != 0) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      total++;
      bad++;
      $display("FAIL drain timeout: busy=%0b pending=%0d want idle",
               busy, sb.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !clear && sram.we_n == 1'b0 && sram.ry == 1'b1) begin
      nacc++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected write: addr=%0h data=%0h want none",
                 sram.w_addr, sram.dataRAM);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write addr/data", {sram.w_addr, sram.dataRAM},
            {e.addr, e.data});
      end
    end
  end

  initial begin
    int n0;
    tbl[0] = '{18'h00001, 18'h00002, 18'h00003, 18'h00004,
               32'h0002_0001, 32'h0004_0003};
    tbl[3] = '{18'h3FF00, 18'h01234, 18'h00ABC, 18'h3C000,
               32'h1234_FF00, 32'hC000_0ABC};
`ifdef RESULT_PACK_SAT_EN
    tbl[1] = '{18'h1FFFF, 18'h20000, 18'h3FFFF, 18'h08000,
               32'h8000_7FFF, 32'h7FFF_FFFF};
    tbl[2] = '{18'h07FFF, 18'h38000, 18'h37FFF, 18'h00000,
               32'h8000_7FFF, 32'h0000_8000};
    tbl[4] = '{18'h10001, 18'h2FFFF, 18'h00000, 18'h3FFFF,
               32'h8000_7FFF, 32'hFFFF_0000};
`else
    tbl[1] = '{18'h1FFFF, 18'h20000, 18'h3FFFF, 18'h08000,
               32'h0000_FFFF, 32'h8000_FFFF};
    tbl[2] = '{18'h07FFF, 18'h38000, 18'h37FFF, 18'h00000,
               32'h8000_7FFF, 32'h0000_7FFF};
    tbl[4] = '{18'h10001, 18'h2FFFF, 18'h00000, 18'h3FFFF,
               32'hFFFF_0001, 32'hFFFF_0000};
`endif
    sram.ry = 1'b0;

    tick();
    do_reset();
    chk("reset outputs",
        {sram.we_n, sram.dataRAM, busy, sram.w_addr,
         wr_count, overflow, wrapped},
        {1'b1, 32'h0, 1'b0, 8'h0, 9'h0, 1'b0, 1'b0});

    sram.ry = 1'b1;
    send(tbl[0], 1'b1);
    chk("basic lo", {sram.we_n, sram.w_addr, sram.dataRAM},
        {1'b0, 8'd0, 32'h0002_0001});
    tick();
    chk("basic hi", {sram.we_n, sram.w_addr, sram.dataRAM},
        {1'b0, 8'd1, 32'h0004_0003});
    tick();
    chk("basic done", {sram.we_n, busy, wr_count},
        {1'b1, 1'b0, 9'd2});

    for (int i = 0; i < 5; i++) begin
      send(tbl[i], 1'b1);
      tick();
    end
    wait_idle(40);
    chk("table count", {wr_count, overflow}, {9'd12, 1'b0});

    do_reset();
    sram.ry = 1'b0;
    send(tbl[3], 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall hold", {sram.we_n, sram.w_addr, sram.dataRAM},
          {1'b0, 8'd0, 32'h1234_FF00});
      tick();
    end
    sram.ry = 1'b1;
    tick();
    chk("stall release", {wr_count, sram.w_addr}, {9'd1, 8'd1});
    wait_idle(10);
    chk("stall done", wr_count, 9'd2);

    do_reset();
    sram.ry = 1'b0;
    n0 = nacc;
    send(tbl[1], 1'b1);
    tick();
    send(tbl[2], 1'b1);
    tick();
    chk("overflow before", {overflow, busy}, {1'b0, 1'b1});
    send(tbl[3], 1'b0);
    chk("overflow set", overflow, 1'b1);
    sram.ry = 1'b1;
    wait_idle(20);
    chk("overflow words", {wr_count, overflow}, {9'd4, 1'b1});
    chk("overflow accepts", 64'(nacc - n0), 64'd4);

    do_reset();
    sram.ry = 1'b1;
    for (int i = 0; i < 127; i++) begin
      send(tbl[i % 5], 1'b1);
      tick();
    end
    wait_idle(20);
    chk("pre-wrap", {wrapped, sram.w_addr, wr_count},
        {1'b0, 8'd254, 9'd254});
    send(tbl[0], 1'b1);
    tick();
    wait_idle(20);
    chk("wrap", {wrapped, sram.w_addr, wr_count},
        {1'b1, 8'd0, 9'd256});
    send(tbl[1], 1'b1);
    tick();
    wait_idle(20);
    chk("post-wrap", {wrapped, sram.w_addr, wr_count},
        {1'b1, 8'd2, 9'd258});

    clear = 1'b1;
    web = 1'b1;
    MU1 = 18'h00005;
    tick();
    clear = 1'b0;
    web = 1'b0;
    chk("clear", {busy, sram.we_n, wrapped, wr_count, sram.w_addr},
        {1'b0, 1'b1, 1'b0, 9'd0, 8'd0});
    tick();
    chk("clear web dropped", {busy, sram.we_n}, {1'b0, 1'b1});

    do_reset();
    sram.ry = 1'b0;
    send(tbl[0], 1'b1);
    tick();
    send(tbl[4], 1'b1);
    tick();
    sram.ry = 1'b1;
    tick();
    chk("in WR_HI", {sram.we_n, sram.w_addr, sram.dataRAM},
        {1'b0, 8'd1, 32'h0004_0003});
    sram.ry = 1'b0;
    rst = 1'b1;
    sb.delete();
    exp_addr = '0;
    tick();
    rst = 1'b0;
    chk("mid reset",
        {sram.we_n, busy, sram.w_addr, wr_count, overflow},
        {1'b1, 1'b0, 8'd0, 9'd0, 1'b0});
    sram.ry = 1'b1;
    n0 = nacc;
    repeat (4) tick();
    chk("no write after reset", {sram.we_n, busy, wr_count},
        {1'b1, 1'b0, 9'd0});
    chk("no accepts after reset", 64'(nacc - n0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Writeback stage directly downstream of the ALU.
- Captures each 4-lane set of 18-bit MAC results (MU1..MU4) on the `web` strobe and buffers it in a 2-entry set FIFO.
- Reduces each lane to 16 bits and packs lane pairs into 32-bit words.
- Writes two words per set to the result SRAM through a ready-gated write port, using an auto-incrementing, wrapping address.

Parameters:
- DATA_W, 18, width of each ALU lane result (signed two's complement)
- OUT_W, 16, packed lane width; 2*OUT_W must equal 32
- ADDR_W, 8, SRAM word-address width
- NUM_WORDS, 256, result region size in words; address wraps after NUM_WORDS-1
- FIFO_DEPTH, 2, result sets buffered (power of 2)

Ports:
- clk  in  1  accelerator (gated) clock
- rst  in  1  synchronous active-high reset
- web  in  1  one-cycle strobe: MU1..MU4 valid this cycle
- MU1  in  DATA_W  lane 0 result
- MU2  in  DATA_W  lane 1 result
- MU3  in  DATA_W  lane 2 result
- MU4  in  DATA_W  lane 3 result
- clear  in  1  synchronous soft reset
- ry  in  1  SRAM ready; a write is accepted on a rising clk edge where we_n=0 and ry=1
- we_n  out  1  SRAM write enable, active low
- w_addr  out  ADDR_W  SRAM write address
- dataRAM  out  32  SRAM write data
- busy  out  1  high when FIFO non-empty or FSM not IDLE
- overflow  out  1  sticky: a set was dropped
- wrapped  out  1  sticky: address wrapped to 0
- wr_count  out  ADDR_W+1  accepted words since reset/clear, saturating at all-ones

Behaviour:
- Reset: rst=1 at a clk edge forces FSM IDLE, FIFO empty, w_addr=0, overflow=0, wrapped=0, wr_count=0. Outputs during/after reset: we_n=1, dataRAM=0, busy=0.
- Reset mid-write abandons the write; no further SRAM access.
- clear: same effect as rst. rst has priority; web in a clear cycle is discarded.
- FIFO push: web=1 and FIFO not full pushes {MU4,MU3,MU2,MU1}.
- web=1 with FIFO full and no pop in the same cycle: set dropped, overflow<=1.
- web=1 with FIFO full and a pop in the same cycle: push accepted.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE: we_n=1, dataRAM=0. FIFO non-empty (head registered) -> WR_LO next edge.
  - Latency: web at edge N gives we_n=0 during cycle N+1.
  - WR_LO: we_n=0, w_addr=addr, dataRAM={R(MU2),R(MU1)} of the FIFO head. Hold until ry=1; on accept: addr++, wr_count++, -> WR_HI.
  - WR_HI: we_n=0, dataRAM={R(MU4),R(MU3)}. On accept: addr++, wr_count++, pop head. Next state is WR_LO if FIFO is still non-empty after the pop, else IDLE.
  - Back-to-back throughput: 2 cycles per set with ry tied high.
- ry=0: address, data and we_n are held stable until accepted; no timeout.
- Address wrap: accept at addr=NUM_WORDS-1 gives addr<=0 and wrapped<=1. Writes continue (overwrite).
- R(x): lane reduction per Optional Feature. Lower lane in dataRAM[15:0].
- busy is combinational from state/FIFO count.

Optional Feature:
- Macro: RESULT_PACK_SAT_EN.
- Defined: R(x) saturates signed DATA_W to signed OUT_W. x>32767 -> 16'h7FFF; x<-32768 -> 16'h8000; else x[15:0].
- Undefined: R(x)=x[OUT_W-1:0] (plain truncation), no comparators.

Test Plan:
- Basic pack: ry=1, web with MU1=1, MU2=2, MU3=3, MU4=4 -> cycle+1: we_n=0, addr 0, data 32'h00020001; next cycle: addr 1, data 32'h00040003; then we_n=1, wr_count=2, busy=0.
- Stall: ry=0 for 5 cycles during WR_LO -> we_n, w_addr, dataRAM held constant. Write completes on the first ry=1 edge; wr_count increments once.
- Overflow: ry=0, three web strobes -> overflow=1 after the third. After releasing ry, exactly 4 words are written (sets 1 and 2 only).
- Saturation: MU1=18'h1FFFF (131071), MU2=18'h20000 (-131072). SAT_EN defined -> 32'h8000_7FFF. Undefined -> 32'h0000_FFFF.
- Wrap: 128 sets at ry=1 -> last word at addr 255, wrapped=1, wr_count=256. Next set writes addr 0.
- Reset mid-op: rst=1 while in WR_HI with FIFO holding 2 sets -> next cycle we_n=1, busy=0, w_addr=0, wr_count=0, overflow=0. No write issued.
